apb3_master: RTL and testbench



---
 rtl/apb3_master.sv | 213 +++++++++++++++++++++
 tb/tb_apb3_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master.sv
// ---------------------------------------------------------------------------
// apb3_master
//
// Single-outstanding APB3 initiator. A command taken on the valid/ready
// command port becomes one SETUP + ACCESS transfer on the APB3 pins. The
// completion (read data, slave error, timeout) comes back on a valid/ready
// response port. Nothing new is accepted until the response is consumed.
//
// Optional feature: define APB3_MASTER_TIMEOUT_EN to build an ACCESS wait
// counter. The transfer is aborted after TIMEOUT_CYCLES ACCESS cycles with
// PREADY low. Without the macro, ACCESS waits for PREADY forever and
// rsp_timeout is tied low.
//
// Parameters
//   ADDR_WIDTH      PADDR / cmd_addr width (>= 2)
//   DATA_WIDTH      PWDATA / PRDATA / cmd_wdata / rsp_rdata width
//   TIMEOUT_CYCLES  ACCESS-cycle limit (>= 1), used only with the timeout
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata   command payload (addr is word-aligned)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_error/rsp_timeout response payload
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA APB3 requester outputs (all registered)
//   PREADY/PRDATA/PSLVERROR        APB3 completer inputs
// ---------------------------------------------------------------------------
module apb3_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB3
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERROR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  // Clears the two byte-lane bits so PADDR is always word aligned.
  localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~ADDR_WIDTH'(3);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb3_master: TIMEOUT_CYCLES must be >= 1");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timeout_hit;

  // wait_q counts the PREADY-low ACCESS cycles already seen, so it equals
  // TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th ACCESS cycle. PREADY in
  // that cycle still completes normally.
  assign timeout_hit = (wait_q == WAIT_LAST) && !PREADY;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Next-state and capture logic.
  // NOTE: every variable gets a default at the top of the block, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef APB3_MASTER_TIMEOUT_EN
    wait_d        = wait_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_SETUP;
          paddr_d  = cmd_addr & ADDR_ALIGN_MASK;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB3_MASTER_TIMEOUT_EN
        wait_d  = '0;
`endif
      end

      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_RESP;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_error_d = PSLVERROR;
`ifdef APB3_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = S_RESP;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
`endif
        end
`ifdef APB3_MASTER_TIMEOUT_EN
        if (!PREADY) begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered strobes decoded from the next state: glitch-free pins that
    // line up exactly with the state they belong to.
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

`ifdef APB3_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  assign PADDR   = paddr_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb3_master.sv
// ---------------------------------------------------------------------------
// tb_apb3_master
//
// Self-checking bench for apb3_master. The slave side is a word-addressed
// memory: writes land in it and reads return its contents. The bench knows
// how many wait states it inserts and whether the timeout is compiled in
// (APB3_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4). From that it predicts the APB
// phases cycle by cycle and the response contents. Outputs are sampled 1 ns
// after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb3_master;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef APB3_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERROR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb3_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERROR  (PSLVERROR)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] slave_word(input int idx);
    if (!mem.exists(idx)) mem[idx] = $urandom;
    return mem[idx];
  endfunction

  // One complete transfer. waits = PREADY-low ACCESS cycles the slave would
  // insert; hold = cycles rsp_ready stays low; busy_cmd keeps cmd_valid high
  // while the response is held. Returns the cycles spent waiting for
  // cmd_ready and the cycle stamp of the accepting edge.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int waits,
                          input bit serr, input int hold, input bit busy_cmd,
                          output int acc_wait, output int acc_cyc);
    logic [AW-1:0] exp_paddr;
    logic [DW-1:0] rd_val, exp_rdata;
    bit            timed, exp_err;
    int            n_access, word;

    word      = int'(addr) / 4;
    exp_paddr = AW'(word * 4);
    timed     = TMO_EN && (waits + 1 > TMO);
    n_access  = timed ? TMO : waits + 1;
    rd_val    = slave_word(word);
    exp_rdata = (timed || wr) ? '0 : rd_val;
    exp_err   = timed || serr;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    rsp_ready = 1'b0;
    acc_wait  = 0;
    while (!cmd_ready && acc_wait < 20) begin
      tick();
      acc_wait++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, acc_wait);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    acc_cyc = cyc;
    // Scramble the command inputs: the bus must hold the registered copy.
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    PREADY = $urandom; PSLVERROR = $urandom; PRDATA = $urandom;

    total++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL setup_ctrl: sel/en/crdy/rval=%b want 1000", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    total++;
    if ({PADDR, PWRITE, PWDATA} !== {exp_paddr, wr, wd}) begin
      bad++;
      $display("FAIL setup_bus: addr=%h wr=%b wdata=%h want %h %b %h", PADDR, PWRITE, PWDATA, exp_paddr, wr, wd);
    end
    tick();

    for (int i = 0; i < n_access; i++) begin
      PREADY    = (i == waits);
      PSLVERROR = (i == waits) ? serr : 1'($urandom);
      PRDATA    = (i == waits && !wr) ? rd_val : DW'($urandom);
      total++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b1100) begin
        bad++;
        $display("FAIL access_ctrl[%0d]: sel/en/rval/crdy=%b want 1100", i, {PSEL, PENABLE, rsp_valid, cmd_ready});
      end
      total++;
      if ({PADDR, PWRITE, PWDATA} !== {exp_paddr, wr, wd}) begin
        bad++;
        $display("FAIL access_bus[%0d]: addr=%h wr=%b wdata=%h want %h %b %h", i, PADDR, PWRITE, PWDATA, exp_paddr, wr, wd);
      end
      tick();
    end
    PREADY = 1'b0; PSLVERROR = $urandom; PRDATA = $urandom;

    for (int h = 0; h <= hold; h++) begin
      cmd_valid = busy_cmd && (h < hold);
      total++;
      if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b1000) begin
        bad++;
        $display("FAIL resp_ctrl[%0d]: rval/sel/en/crdy=%b want 1000", h, {rsp_valid, PSEL, PENABLE, cmd_ready});
      end
      total++;
      if ({rsp_rdata, rsp_error, rsp_timeout} !== {exp_rdata, exp_err, timed}) begin
        bad++;
        $display("FAIL resp_data[%0d]: rdata=%h err=%b tmo=%b want %h %b %b", h, rsp_rdata, rsp_error, rsp_timeout, exp_rdata, exp_err, timed);
      end
      if (h < hold) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, cmd_ready, PSEL, PADDR} !== {1'b0, 1'b1, 1'b0, exp_paddr}) begin
      bad++;
      $display("FAIL back_to_idle: rval/crdy/sel=%b addr=%h want 010 %h", {rsp_valid, cmd_ready, PSEL}, PADDR, exp_paddr);
    end
    if (wr && !timed) mem[word] = wd;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERROR = 1'b0;
    #3;
    total++;
    if ({cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: crdy/rval/sel/en/wr=%b want 10000", {cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE});
    end
    total++;
    if ({PADDR, PWDATA, rsp_rdata, rsp_error, rsp_timeout} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h err=%b tmo=%b want all 0", PADDR, PWDATA, rsp_rdata, rsp_error, rsp_timeout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait_write();
    int aw, ac;
    run_xfer(1'b1, 16'h0004, 32'h0000_0001, 0, 1'b0, 0, 1'b0, aw, ac);
  endtask

  task automatic test_wait_read();
    int aw, ac;
    mem[2] = 32'hABCD_5678;
    run_xfer(1'b0, 16'h0008, $urandom, 3, 1'b0, 0, 1'b0, aw, ac);
  endtask

  task automatic test_slave_error();
    int aw, ac;
    run_xfer(1'b0, 16'h0013, $urandom, 1, 1'b1, 0, 1'b0, aw, ac);
  endtask

  task automatic test_backpressure();
    int aw, ac;
    run_xfer(1'b1, 16'h0020, $urandom, 0, 1'b0, 10, 1'b1, aw, ac);
    run_xfer(1'b0, 16'h0020, $urandom, 0, 1'b0, 0, 1'b0, aw, ac);
    total++;
    if (aw !== 0) begin
      bad++;
      $display("FAIL accept_after_resp: waited %0d cycles want 0", aw);
    end
  endtask

  task automatic test_back_to_back();
    int aw, ac, prev;
    // SETUP, ACCESS, RESP and the IDLE cycle that takes the next command.
    run_xfer(1'b1, 16'h0040, $urandom, 0, 1'b0, 0, 1'b0, aw, prev);
    for (int i = 0; i < 3; i++) begin
      run_xfer(1'($urandom), 16'h0044 + AW'(4 * i), $urandom, 0, 1'b0, 0, 1'b0, aw, ac);
      total++;
      if (ac - prev !== 4) begin
        bad++;
        $display("FAIL b2b_period[%0d]: %0d cycles want 4", i, ac - prev);
      end
      prev = ac;
    end
  endtask

  task automatic test_timeout();
    int aw, ac;
    // In a build without the timeout, these become plain long-wait transfers.
    run_xfer(1'b0, 16'h0050, $urandom, 12, 1'b0, 0, 1'b0, aw, ac);
    run_xfer(1'b1, 16'h0054, $urandom, TMO - 1, 1'b1, 0, 1'b0, aw, ac);
    run_xfer(1'b0, 16'h0054, $urandom, TMO, 1'b0, 0, 1'b0, aw, ac);
  endtask

  task automatic test_random();
    int aw, ac;
    for (int i = 0; i < 16; i++) begin
      run_xfer(1'($urandom), AW'($urandom_range(0, 63)), $urandom,
               int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3)), 1'($urandom), aw, ac);
    end
  endtask

  task automatic test_async_reset();
    int aw, ac, n;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0030; cmd_wdata = 32'h1234_5678;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0; PREADY = 1'b0;
    tick();
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL async_reset_ctrl: sel/en/rval/crdy=%b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
    end
    total++;
    if ({PADDR, PWRITE, PWDATA} !== '0) begin
      bad++;
      $display("FAIL async_reset_bus: addr=%h wr=%b wdata=%h want 0", PADDR, PWRITE, PWDATA);
    end
    PREADY = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
        bad++;
        $display("FAIL dropped_xfer[%0d]: rval/sel/crdy=%b want 001", i, {rsp_valid, PSEL, cmd_ready});
      end
    end
    PREADY = 1'b0;
    run_xfer(1'b0, 16'h0034, $urandom, 2, 1'b0, 1, 1'b0, aw, ac);
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
